// File: rtl/riscv_alu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_alu_iter
//  Description : EX-stage ALU with single-cycle logic/shift/compare ops and an
//                iterative restoring divider for DIV/DIVU/REM/REMU. The block
//                stalls the pipeline through ready_o while a division is busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu_iter #(
    parameter int WIDTH        = 32,
    parameter int CNT_W        = $clog2(WIDTH) + 1,
    parameter int ALU_OP_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [WIDTH-1:0]        operand_a_i,
    input  logic [WIDTH-1:0]        operand_b_i,
    output logic [WIDTH-1:0]        result_o,
    output logic                    comparison_result_o,
    output logic                    ready_o,
    input  logic                    ex_ready_i
);

    localparam int c_SHW = $clog2(WIDTH);

    // Operator encoding shared with the decoder (riscv_defines)
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_ADD  = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SUB  = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_XOR  = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_OR   = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_AND  = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SRA  = 7'b0100100;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SRL  = 7'b0100101;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SLL  = 7'b0100111;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_LTS  = 7'b0000000;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_LTU  = 7'b0000001;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SLTS = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SLTU = 7'b0000011;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_LES  = 7'b0000100;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_LEU  = 7'b0000101;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_GTS  = 7'b0001000;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_GTU  = 7'b0001001;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_GES  = 7'b0001010;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_GEU  = 7'b0001011;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_EQ   = 7'b0001100;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_NE   = 7'b0001101;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_DIVU = 7'b0110000;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_DIV  = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_REMU = 7'b0110010;
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_REM  = 7'b0110011;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CALC   = 2'd1;
    localparam logic [1:0] c_ST_FINISH = 2'd2;

    localparam logic [WIDTH-1:0] c_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [c_SHW-1:0] w_shamt;
    logic             w_lts;
    logic             w_ltu;
    logic             w_eq;
    logic             w_cmp;
    logic [WIDTH-1:0] w_alu;

    logic             w_is_div;
    logic             w_div_signed;
    logic             w_op_rem;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_fit;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_final;

    // ---------------- single-cycle datapath ----------------
    assign w_shamt = operand_b_i[c_SHW-1:0];
    assign w_lts   = $signed(operand_a_i) < $signed(operand_b_i);
    assign w_ltu   = operand_a_i < operand_b_i;
    assign w_eq    = operand_a_i == operand_b_i;

    // Scalar compare outcome, purely from the current operator and operands
    always_comb begin
        w_cmp = 1'b0;
        case (operator_i)
            c_ALU_EQ:             w_cmp = w_eq;
            c_ALU_NE:             w_cmp = ~w_eq;
            c_ALU_LTS, c_ALU_SLTS: w_cmp = w_lts;
            c_ALU_LTU, c_ALU_SLTU: w_cmp = w_ltu;
            c_ALU_GES:            w_cmp = ~w_lts;
            c_ALU_GEU:            w_cmp = ~w_ltu;
            c_ALU_GTS:            w_cmp = ~w_lts & ~w_eq;
            c_ALU_GTU:            w_cmp = ~w_ltu & ~w_eq;
            c_ALU_LES:            w_cmp = w_lts | w_eq;
            c_ALU_LEU:            w_cmp = w_ltu | w_eq;
            default:              w_cmp = 1'b0;
        endcase
    end

    assign comparison_result_o = w_cmp;

    // Single-cycle result; division and unknown operators yield zero here
    always_comb begin
        w_alu = '0;
        case (operator_i)
            c_ALU_ADD: w_alu = operand_a_i + operand_b_i;
            c_ALU_SUB: w_alu = operand_a_i - operand_b_i;
            c_ALU_AND: w_alu = operand_a_i & operand_b_i;
            c_ALU_OR:  w_alu = operand_a_i | operand_b_i;
            c_ALU_XOR: w_alu = operand_a_i ^ operand_b_i;
            c_ALU_SLL: w_alu = operand_a_i << w_shamt;
            c_ALU_SRL: w_alu = operand_a_i >> w_shamt;
            c_ALU_SRA: w_alu = $unsigned($signed(operand_a_i) >>> w_shamt);
            c_ALU_EQ, c_ALU_NE, c_ALU_LTS, c_ALU_LTU, c_ALU_GES, c_ALU_GEU,
            c_ALU_GTS, c_ALU_GTU, c_ALU_LES, c_ALU_LEU:
                       w_alu = {WIDTH{w_cmp}};
            c_ALU_SLTS, c_ALU_SLTU:
                       w_alu = {{(WIDTH-1){1'b0}}, w_cmp};
            default:   w_alu = '0;
        endcase
    end

    // ---------------- division issue decode ----------------
    assign w_is_div     = (operator_i == c_ALU_DIV)  || (operator_i == c_ALU_DIVU) ||
                          (operator_i == c_ALU_REM)  || (operator_i == c_ALU_REMU);
    assign w_div_signed = (operator_i == c_ALU_DIV)  || (operator_i == c_ALU_REM);
    assign w_op_rem     = (operator_i == c_ALU_REM)  || (operator_i == c_ALU_REMU);
    assign w_a_neg      = w_div_signed & operand_a_i[WIDTH-1];
    assign w_b_neg      = w_div_signed & operand_b_i[WIDTH-1];
    assign w_a_mag      = w_a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
    assign w_b_mag      = w_b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
    assign w_div_zero   = operand_b_i == '0;
    assign w_div_ovf    = w_div_signed && (operand_a_i == c_INT_MIN) &&
                          (operand_b_i == {WIDTH{1'b1}});
    assign w_special    = w_div_zero | w_div_ovf;

    // Divide-by-zero and signed overflow resolve straight from the operands
    assign w_special_res = w_div_zero ? (w_op_rem ? operand_a_i : {WIDTH{1'b1}})
                                      : (w_op_rem ? '0 : c_INT_MIN);

    // ---------------- restoring step ----------------
    // The shifted partial remainder needs one extra bit since the divisor
    // magnitude can use the full width in unsigned mode.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dvs};
    assign w_fit      = ~w_diff[WIDTH];
    assign w_rem_step = w_fit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], w_fit};
    assign w_q_fix    = r_neg_q ? (~w_quo_step + 1'b1) : w_quo_step;
    assign w_r_fix    = r_neg_r ? (~w_rem_step + 1'b1) : w_rem_step;
    assign w_final    = r_is_rem ? w_r_fix : w_q_fix;

    // ---------------- FSM ----------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake and output mux; reset forces the combinational path
    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b1;
        result_o    = w_alu;
        case (r_state)
            c_ST_IDLE: begin
                if (enable_i && w_is_div) begin
                    ready_o     = 1'b0;
                    w_state_nxt = w_special ? c_ST_FINISH : c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                ready_o  = 1'b0;
                result_o = '0;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = c_ST_FINISH;
                end
            end
            c_ST_FINISH: begin
                result_o = r_result;
                if (ex_ready_i) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (rst) begin
            w_state_nxt = c_ST_IDLE;
            ready_o     = 1'b1;
            result_o    = w_alu;
        end
    end

    // Divider datapath: latch at issue, iterate in CALC, capture final result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (enable_i && w_is_div) begin
                        r_quo    <= w_a_mag;
                        r_rem    <= '0;
                        r_dvs    <= w_b_mag;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_is_rem <= w_op_rem;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_result <= w_special_res;
                    end
                end
                c_ST_CALC: begin
                    r_quo <= w_quo_step;
                    r_rem <= w_rem_step;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/riscv_alu_iter.md
# riscv_alu_iter

Parametrised-width EX-stage ALU, successor to the single-cycle basic ALU. Adds an iterative restoring divider for DIV/DIVU/REM/REMU alongside the single-cycle logic, shift and compare ops. Sits in the execute stage and stalls the pipeline through `ready_o`/`ex_ready_i` while a division is in flight.

## Interface
- `WIDTH`, default 32: operand and result width; must be at least 8 and a power of two.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width; derived, not to be overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enable_i`  in  1  an operation is issued this cycle.
- `operator_i`  in  ALU_OP_WIDTH  operator, `riscv_defines` encoding.
- `operand_a_i`  in  WIDTH  operand A; dividend for division.
- `operand_b_i`  in  WIDTH  operand B; divisor or shift amount.
- `result_o`  out  WIDTH  result.
- `comparison_result_o`  out  1  scalar compare outcome; branch condition.
- `ready_o`  out  1  result valid and the block can accept a new op.
- `ex_ready_i`  in  1  downstream consumes the result this cycle.

## Operation
- Single-cycle ops are fully combinational, with `ready_o`=1:
  - ADD, SUB: modulo 2^WIDTH.
  - AND, OR, XOR.
  - SLL, SRL, SRA: shift amount is `operand_b_i[$clog2(WIDTH)-1:0]`.
  - EQ, NE, LTS, LTU, GES, GEU, GTS, GTU, LES, LEU: `result_o` is all-ones if true, else zero.
  - SLTS, SLTU: `result_o` = {0…, cmp}.
- Unsupported operators give `result_o`=0 and `ready_o`=1.
- Division FSM:
  - States: IDLE, CALC, FINISH.
  - IDLE: `ready_o` is combinationally 0 when `enable_i` is high and the operator is DIV, DIVU, REM or REMU.
  - At that edge the block latches the op, the operand magnitudes and the sign flags.
  - Next state is FINISH for the special cases below; otherwise CALC with the counter = WIDTH.
  - CALC: restoring division, one quotient bit per cycle.
    - Shift {rem, quo} left by 1.
    - If rem ≥ divisor: subtract it and set the quotient LSB.
    - Decrement the counter; on 1→0 go to FINISH.
    - `ready_o`=0 throughout.
  - FINISH: apply the sign fix-up and drive `result_o` from a register. `ready_o`=1.
    - Go to IDLE when `ex_ready_i`=1; otherwise hold the result.
- Signed rules (RISC-V):
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Special cases, resolved without CALC:
  - Divide by zero: quotient = all-ones; remainder = dividend.
  - Signed overflow (−2^(WIDTH−1) / −1): quotient = −2^(WIDTH−1); remainder = 0.
- In CALC and FINISH, `operator_i`, the operands and `enable_i` are ignored. The pipeline holds them, but correctness does not depend on that.
- `comparison_result_o` is always derived from the current `operator_i` and operands. It is independent of the FSM.

## Timing
- Reset (`rst`=1 at an edge): state goes to IDLE; quotient, remainder, counter and result registers clear to 0.
- While `rst` is high: `ready_o`=1, and `result_o` is the combinational result of the current inputs; 0 for division ops.
- Reset mid-division aborts the op. No result is produced, and the next cycle is IDLE.
- Single-cycle op latency is 0 cycles; the result is valid in the issue cycle.
- Normal division: issue at cycle 0 (`ready_o`=0), CALC in cycles 1..WIDTH, FINISH at cycle WIDTH+1 (`ready_o`=1).
- Special-case division: FINISH at cycle 1.
- FINISH holds for as many cycles as `ex_ready_i` stays low. `result_o` is stable throughout.
- Back-to-back divisions: a new division can be issued in the cycle after the FINISH handshake, never in the same cycle.
- `enable_i`=0 in IDLE with a division operator does not start the FSM. `ready_o` stays 1.

## Test plan
- WIDTH=32, ADD 0xFFFFFFFF+1 -> 0; SRA 0x80000000 by 4 -> 0xF8000000; SLTS −1 vs 1 -> 1; all with `ready_o`=1 in the same cycle.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2; `ready_o` low for exactly 33 cycles, high at cycle 33.
- DIV −7/2 -> −3 (0xFFFFFFFD); REM −7/2 -> −1; DIV 7/−2 -> −3; REM 7/−2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/−1 -> 0x80000000; REM 0x80000000/−1 -> 0. Each is ready at cycle 1.
- DIVU finishes with `ex_ready_i` held low for 5 cycles: `result_o` is stable and `ready_o`=1 throughout. Operands changed during CALC do not affect the result.
- `rst` asserted at CALC cycle 10: IDLE next cycle, `ready_o`=1. A new DIVU 9/3 then returns 3 with full latency.
- WIDTH=8: DIVU 255/16 -> 15; REMU -> 15; latency 9 cycles.
